// File: rtl/div_seq.sv
// Iterative restoring divider, signed/unsigned, one quotient bit per clock; result after WIDTH+1 cycles.
// start is ignored while busy; optional dz port enabled by DIV_DZ_FLAG_EN.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             start,
  input  logic             signctl,
  input  logic             remsel,
  output logic [WIDTH-1:0] dout,
  output logic             drdy,
`ifdef DIV_DZ_FLAG_EN
  output logic             dz,
`endif
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd, dvs, rem, qacc, quo, rmd;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r, dz_pend;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   rem_sh, rem_sub;

  always_comb begin
    mag_a   = (signctl && A[WIDTH-1]) ? -A : A;
    mag_b   = (signctl && B[WIDTH-1]) ? -B : B;
    rem_sh  = {rem, dvd[cnt]};
    // borrow out of the WIDTH+1 bit subtract means the divisor did not fit
    rem_sub = rem_sh - {1'b0, dvs};
  end

  assign dout = remsel ? rmd : quo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      qacc    <= '0;
      quo     <= '0;
      rmd     <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_pend <= 1'b0;
      drdy    <= 1'b0;
      busy    <= 1'b0;
`ifdef DIV_DZ_FLAG_EN
      dz      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            neg_q <= signctl & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r <= signctl & A[WIDTH-1];
            dvs   <= mag_b;
            rem   <= '0;
            qacc  <= '0;
            cnt   <= CW'(WIDTH - 1);
            drdy  <= 1'b0;
            busy  <= 1'b1;
`ifdef DIV_DZ_FLAG_EN
            dz    <= 1'b0;
`endif
            // divide by zero skips the iteration and keeps the raw dividend
            if (B == '0) begin
              dz_pend <= 1'b1;
              dvd     <= A;
              state   <= FIX;
            end else begin
              dz_pend <= 1'b0;
              dvd     <= mag_a;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (!rem_sub[WIDTH]) begin
            rem  <= rem_sub[WIDTH-1:0];
            qacc <= {qacc[WIDTH-2:0], 1'b1};
          end else begin
            rem  <= rem_sh[WIDTH-1:0];
            qacc <= {qacc[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          if (dz_pend) begin
            quo <= '1;
            rmd <= dvd;
          end else begin
            quo <= neg_q ? -qacc : qacc;
            rmd <= neg_r ? -rem : rem;
          end
`ifdef DIV_DZ_FLAG_EN
          dz    <= dz_pend;
`endif
          busy  <= 1'b0;
          drdy  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Randomized self-checking bench for div_seq against an arithmetic reference model.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic        start = 1'b0, signctl = 1'b0, remsel = 1'b0;
  logic [31:0] dout;
  logic        drdy, busy;
`ifdef DIV_DZ_FLAG_EN
  logic        dz;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .start(start), .signctl(signctl),
    .remsel(remsel), .dout(dout), .drdy(drdy),
`ifdef DIV_DZ_FLAG_EN
    .dz(dz),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sc,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sc) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic read_res(output logic [31:0] q, output logic [31:0] r);
    remsel = 1'b0; #1 q = dout;
    remsel = 1'b1; #1 r = dout;
    remsel = 1'b0;
  endtask

  // accept one op, optionally scramble the inputs afterwards, wait for drdy
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sc,
                        input bit scramble, output int lat,
                        output logic [31:0] q, output logic [31:0] r);
    @(negedge clk);
    A = a; B = b; signctl = sc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    check("drdy_after_accept", drdy, 1'b0);
    if (scramble) begin
      A = $urandom; B = $urandom; signctl = ~sc;
    end
    lat = 0;
    do begin
      @(posedge clk); lat++; @(negedge clk);
    end while (!drdy && lat < 100);
    read_res(q, r);
  endtask

  task automatic op_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sc, input bit scramble);
    int lat;
    logic [31:0] q, r, eq, er;
    model(a, b, sc, eq, er);
    run_op(a, b, sc, scramble, lat, q, r);
    check({tag, "_lat"}, lat, (b == 32'd0) ? 1 : 33);
    check({tag, "_q"}, q, eq);
    check({tag, "_r"}, r, er);
    check({tag, "_busy_done"}, busy, 1'b0);
  endtask

  initial begin
    int lat, n;
    logic [31:0] q, r, eq, er;
    logic [31:0] ta[4], tb[4];
    logic        ts[4];

    #12;
    check("rst_dout", dout, 32'd0);
    check("rst_drdy", drdy, 1'b0);
    check("rst_busy", busy, 1'b0);
`ifdef DIV_DZ_FLAG_EN
    check("rst_dz", dz, 1'b0);
`endif
    @(negedge clk); rst = 1'b0;

    // directed cases with literal expectations
    run_op(32'd100, 32'd7, 1'b0, 1'b1, lat, q, r);
    check("u100_7_lat", lat, 33);
    check("u100_7_q", q, 32'd14);
    check("u100_7_r", r, 32'd2);
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, lat, q, r);
    check("sm100_7_q", q, 32'hFFFF_FFF2);
    check("sm100_7_r", r, 32'hFFFF_FFFE);
    run_op(32'h1234_5678, 32'd0, 1'b1, 1'b1, lat, q, r);
    check("dz_lat", lat, 1);
    check("dz_q", q, 32'hFFFF_FFFF);
    check("dz_r", r, 32'h1234_5678);
`ifdef DIV_DZ_FLAG_EN
    check("dz_flag", dz, 1'b1);
`endif
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, lat, q, r);
    check("sovf_q", q, 32'h8000_0000);
    check("sovf_r", r, 32'd0);
`ifdef DIV_DZ_FLAG_EN
    check("dz_clear", dz, 1'b0);
`endif
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, q, r);
    check("uovf_q", q, 32'd0);
    check("uovf_r", r, 32'h8000_0000);
    op_check("s_neg_neg", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 1'b0);
    op_check("s_pos_neg", 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b0);
    op_check("u_max", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);

    // DONE holds its result
    repeat (3) @(negedge clk);
    check("done_hold_drdy", drdy, 1'b1);
    read_res(q, r);
    check("done_hold_q", q, 32'hFFFF_FFFF);

    // start pulse during CALC is ignored
    @(negedge clk);
    A = 32'd1000; B = 32'd33; signctl = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    A = 32'd5; B = 32'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 6;
    while (!drdy && n < 100) begin @(posedge clk); n++; @(negedge clk); end
    check("midstart_lat", n, 33);
    read_res(q, r);
    check("midstart_q", q, 32'd30);
    check("midstart_r", r, 32'd10);
    repeat (3) @(negedge clk);
    check("midstart_ignored", drdy, 1'b1);

    // back-to-back with start held high
    for (int i = 0; i < 4; i++) begin
      ta[i] = $urandom; tb[i] = $urandom_range(1, 5000); ts[i] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    A = ta[0]; B = tb[0]; signctl = ts[0]; start = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(posedge clk); n++; @(negedge clk); end while (!drdy && n < 100);
      check("b2b_lat", n, 33);
      read_res(q, r);
      model(ta[k], tb[k], ts[k], eq, er);
      check("b2b_q", q, eq);
      check("b2b_r", r, er);
      if (k < 3) begin
        A = ta[k+1]; B = tb[k+1]; signctl = ts[k+1];
        @(posedge clk); @(negedge clk);
        check("b2b_gap", drdy, 1'b0);
      end else begin
        start = 1'b0;
      end
    end

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    A = 32'hDEAD_BEEF; B = 32'd3; signctl = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_dout_q", dout, 32'd0);
    check("arst_drdy", drdy, 1'b0);
    check("arst_busy", busy, 1'b0);
    remsel = 1'b1; #1;
    check("arst_dout_r", dout, 32'd0);
    remsel = 1'b0;
    @(negedge clk); rst = 1'b0;
    op_check("after_rst", 32'hDEAD_BEEF, 32'd3, 1'b0, 1'b1);

    // randomized operations against the reference model
    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra, rb;
      logic        rs;
      ra = $urandom;
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2, 3:    rb = $urandom_range(1, 255);
        4:       rb = 32'hFFFF_FFFF - $urandom_range(0, 255);
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      op_check("rand", ra, rb, rs, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
